// File: rtl/ahb_master_sel.sv
// AHB master selector: picks the bus owner from the grant vector and sequences
// ownership across fixed-length bursts, locked transfers and split/retry responses.
module ahb_master_sel (
   input  logic        hclk,
   input  logic        hrst_n,
   input  logic [15:0] grant_req,
   input  logic        hready,
   input  logic [1:0]  htrans,
   input  logic [2:0]  hburst,
   input  logic        hlock_m,
   input  logic [1:0]  hresp,
   input  logic [15:0] hsplit,
   output logic [15:0] hgrant,
   output logic [3:0]  hmaster,
   output logic [3:0]  hmaster_d,
   output logic        hmastlock,
   output logic [15:0] split_mask
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_SPLIT = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_LOCK} state_e;

   state_e      state_q, state_d;
   logic [3:0]  count_q, count_d;
   logic [15:0] hgrant_q, hgrant_d;
   logic [3:0]  hmaster_q;
   logic [3:0]  hmaster_data_q;
   logic        hmastlock_q;
   logic [15:0] split_mask_q, split_mask_d;
   logic [15:0] candidate;
   logic [15:0] split_set;
   logic [3:0]  sel_idx;
   logic        arb_point;
   logic        abort;

   // Lowest set bit wins; an empty vector selects the default master 0.
   function automatic logic [3:0] lowest_idx(input logic [15:0] v);
      lowest_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) lowest_idx = 4'(i);
      end
   endfunction

   function automatic logic [3:0] burst_beats_left(input logic [2:0] burst);
      case (burst[2:1])
         2'b01:   burst_beats_left = 4'd3;
         2'b10:   burst_beats_left = 4'd7;
         2'b11:   burst_beats_left = 4'd15;
         default: burst_beats_left = 4'd0;
      endcase
   endfunction

   always_comb begin
      candidate = grant_req & ~split_mask_q;
      sel_idx   = lowest_idx(candidate);
      arb_point = hready && ((state_q == ST_IDLE) ||
                             (state_q == ST_BURST && count_q == 4'd0 && !hlock_m));
      hgrant_d  = arb_point ? (16'h0001 << sel_idx) : hgrant_q;

      // A non-OKAY response is acted on in its first (wait-state) cycle.
      abort     = !hready && (hresp != RESP_OKAY);
      split_set = (!hready && hresp == RESP_SPLIT) ? (16'h0001 << hmaster_data_q) : 16'h0000;
      split_mask_d = ((split_mask_q & ~hsplit) | split_set) & 16'hFFFE;

      count_d = count_q;
      state_d = state_q;
      if (abort) begin
         count_d = 4'd0;
         state_d = ST_IDLE;
      end else if (hready) begin
         case (htrans)
            TR_NONSEQ: count_d = burst_beats_left(hburst);
            TR_SEQ:    count_d = (count_q != 4'd0) ? count_q - 4'd1 : 4'd0;
            default:   count_d = count_q;
         endcase
         if (hlock_m) begin
            state_d = ST_LOCK;
         end else begin
            case (state_q)
               ST_IDLE:  if (htrans == TR_NONSEQ && count_d != 4'd0) state_d = ST_BURST;
               ST_BURST: if (count_d == 4'd0) state_d = ST_IDLE;
               ST_LOCK:  if (htrans == TR_IDLE || htrans == TR_NONSEQ) state_d = ST_IDLE;
               default:  state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge hclk or negedge hrst_n) begin
      if (!hrst_n) begin
         state_q        <= ST_IDLE;
         count_q        <= 4'd0;
         hgrant_q       <= 16'h0001;
         hmaster_q      <= 4'd0;
         hmaster_data_q <= 4'd0;
         hmastlock_q    <= 1'b0;
         split_mask_q   <= 16'h0000;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         hgrant_q     <= hgrant_d;
         split_mask_q <= split_mask_d;
         if (hready) begin
            hmaster_q      <= lowest_idx(hgrant_q);
            hmaster_data_q <= hmaster_q;
            hmastlock_q    <= hlock_m && (htrans != TR_IDLE);
         end
      end
   end

   assign hgrant     = hgrant_q;
   assign hmaster    = hmaster_q;
   assign hmaster_d  = hmaster_data_q;
   assign hmastlock  = hmastlock_q;
   assign split_mask = split_mask_q;

endmodule

// File: tb/tb_ahb_master_sel.sv
// Directed bench for ahb_master_sel: each step queues the outputs expected after
// the next clock edge and an independent monitor pops and compares them.
module tb_ahb_master_sel;

   localparam logic [1:0] IDL = 2'b00, NSQ = 2'b10, SQ = 2'b11;
   localparam logic [1:0] OK = 2'b00, ERR = 2'b01, RTY = 2'b10, SPL = 2'b11;

   logic        hclk;
   logic        hrst_n;
   logic [15:0] grant_req;
   logic        hready;
   logic [1:0]  htrans;
   logic [2:0]  hburst;
   logic        hlock_m;
   logic [1:0]  hresp;
   logic [15:0] hsplit;
   logic [15:0] hgrant;
   logic [3:0]  hmaster;
   logic [3:0]  hmaster_d;
   logic        hmastlock;
   logic [15:0] split_mask;

   typedef struct packed {
      logic [15:0] id;
      logic [15:0] g;
      logic [3:0]  hm;
      logic [3:0]  hmd;
      logic        ml;
      logic [15:0] sm;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   step_id = 0;

   ahb_master_sel dut (
      .hclk       (hclk),
      .hrst_n     (hrst_n),
      .grant_req  (grant_req),
      .hready     (hready),
      .htrans     (htrans),
      .hburst     (hburst),
      .hlock_m    (hlock_m),
      .hresp      (hresp),
      .hsplit     (hsplit),
      .hgrant     (hgrant),
      .hmaster    (hmaster),
      .hmaster_d  (hmaster_d),
      .hmastlock  (hmastlock),
      .split_mask (split_mask)
   );

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   task automatic cmp(input string nm, input int id, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL step%0d %s: got %h expected %h", id, nm, got, exp);
      end
   endtask

   // Monitor: outputs settle shortly after each clock edge or reset assertion.
   initial begin
      exp_t e;
      forever begin
         @(posedge hclk or negedge hrst_n);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("hgrant",     int'(e.id), hgrant,             e.g);
            cmp("hmaster",    int'(e.id), {12'h0, hmaster},   {12'h0, e.hm});
            cmp("hmaster_d",  int'(e.id), {12'h0, hmaster_d}, {12'h0, e.hmd});
            cmp("hmastlock",  int'(e.id), {15'h0, hmastlock}, {15'h0, e.ml});
            cmp("split_mask", int'(e.id), split_mask,         e.sm);
         end
      end
   end

   function automatic exp_t mk(input logic [15:0] g, input logic [3:0] hm, input logic [3:0] hmd,
                               input logic ml, input logic [15:0] sm);
      exp_t e;
      e.id  = 16'(step_id);
      e.g   = g;
      e.hm  = hm;
      e.hmd = hmd;
      e.ml  = ml;
      e.sm  = sm;
      return e;
   endfunction

   // Called at a falling clock edge; drives one cycle of inputs and waits for the next falling edge.
   task automatic step(input logic [15:0] req, input logic rdy, input logic [1:0] tr, input logic [2:0] hb,
                       input logic lk, input logic [1:0] rs, input logic [15:0] sp,
                       input logic [15:0] eg, input logic [3:0] ehm, input logic [3:0] ehmd,
                       input logic eml, input logic [15:0] esm);
      step_id++;
      grant_req = req;
      hready    = rdy;
      htrans    = tr;
      hburst    = hb;
      hlock_m   = lk;
      hresp     = rs;
      hsplit    = sp;
      exp_q.push_back(mk(eg, ehm, ehmd, eml, esm));
      @(negedge hclk);
   endtask

   initial begin
      hrst_n = 1'b0;
      grant_req = 16'h0; hready = 1'b1; htrans = IDL; hburst = 3'b000;
      hlock_m = 1'b0; hresp = OK; hsplit = 16'h0;
      @(negedge hclk);
      // Reset holds the default owner even with requests pending.
      step(16'h0024, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0001, 0, 0, 0, 16'h0);
      step(16'h0000, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0001, 0, 0, 0, 16'h0);
      hrst_n = 1'b1;
      // No requests: default master forever.
      for (int i = 0; i < 3; i++)
         step(16'h0000, 1, IDL, 3'b000, 0, OK, 16'h0, 16'h0001, 0, 0, 0, 16'h0);
      // Lowest of masters 2 and 5, then address/data owner pipeline.
      step(16'h0024, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0004, 0, 0, 0, 16'h0);
      step(16'h0024, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0004, 2, 0, 0, 16'h0);
      step(16'h0024, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0004, 2, 2, 0, 16'h0);
      // INCR4 by master 3; master 5 waits for the burst to finish.
      step(16'h0008, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0008, 2, 2, 0, 16'h0);
      step(16'h0008, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0008, 3, 2, 0, 16'h0);
      step(16'h0008, 1, NSQ, 3'b011, 0, OK, 16'h0,  16'h0008, 3, 3, 0, 16'h0);
      step(16'h0020, 1, SQ,  3'b011, 0, OK, 16'h0,  16'h0008, 3, 3, 0, 16'h0);
      step(16'h0020, 1, SQ,  3'b011, 0, OK, 16'h0,  16'h0008, 3, 3, 0, 16'h0);
      step(16'h0020, 1, SQ,  3'b011, 0, OK, 16'h0,  16'h0008, 3, 3, 0, 16'h0);
      step(16'h0020, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0020, 3, 3, 0, 16'h0);
      step(16'h0020, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0020, 5, 3, 0, 16'h0);
      // Undefined-length INCR never blocks arbitration.
      step(16'h0020, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0020, 5, 5, 0, 16'h0);
      step(16'h0008, 1, NSQ, 3'b001, 0, OK, 16'h0,  16'h0008, 5, 5, 0, 16'h0);
      step(16'h0020, 1, SQ,  3'b001, 0, OK, 16'h0,  16'h0020, 3, 5, 0, 16'h0);
      step(16'h0020, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0020, 5, 3, 0, 16'h0);
      // Locked sequence by master 4 while master 1 requests.
      step(16'h0010, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0010, 5, 5, 0, 16'h0);
      step(16'h0010, 1, NSQ, 3'b000, 1, OK, 16'h0,  16'h0010, 4, 5, 1, 16'h0);
      for (int i = 0; i < 5; i++)
         step(16'h0002, 1, NSQ, 3'b000, 1, OK, 16'h0, 16'h0010, 4, 4, 1, 16'h0);
      step(16'h0002, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0010, 4, 4, 0, 16'h0);
      step(16'h0002, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0002, 4, 4, 0, 16'h0);
      step(16'h0002, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0002, 1, 4, 0, 16'h0);
      step(16'h0002, 1, IDL, 3'b000, 0, OK, 16'h0,  16'h0002, 1, 1, 0, 16'h0);
      // RETRY breaks master 1's lock.
      step(16'h0002, 1, NSQ, 3'b000, 1, OK,  16'h0, 16'h0002, 1, 1, 1, 16'h0);
      step(16'h0004, 1, NSQ, 3'b000, 1, OK,  16'h0, 16'h0002, 1, 1, 1, 16'h0);
      step(16'h0004, 0, NSQ, 3'b000, 0, RTY, 16'h0, 16'h0002, 1, 1, 1, 16'h0);
      step(16'h0004, 1, IDL, 3'b000, 0, RTY, 16'h0, 16'h0004, 1, 1, 0, 16'h0);
      step(16'h0004, 1, IDL, 3'b000, 0, OK,  16'h0, 16'h0004, 2, 1, 0, 16'h0);
      // SPLIT of master 6, then resume via hsplit[6].
      step(16'h0040, 1, IDL, 3'b000, 0, OK,  16'h0,    16'h0040, 2, 2, 0, 16'h0000);
      step(16'h0040, 1, IDL, 3'b000, 0, OK,  16'h0,    16'h0040, 6, 2, 0, 16'h0000);
      step(16'h0040, 1, IDL, 3'b000, 0, OK,  16'h0,    16'h0040, 6, 6, 0, 16'h0000);
      step(16'h0040, 0, IDL, 3'b000, 0, SPL, 16'h0,    16'h0040, 6, 6, 0, 16'h0040);
      step(16'h0040, 1, IDL, 3'b000, 0, SPL, 16'h0,    16'h0001, 6, 6, 0, 16'h0040);
      step(16'h0040, 1, IDL, 3'b000, 0, OK,  16'h0,    16'h0001, 0, 6, 0, 16'h0040);
      step(16'h0040, 1, IDL, 3'b000, 0, OK,  16'h0,    16'h0001, 0, 0, 0, 16'h0040);
      step(16'h0040, 1, IDL, 3'b000, 0, OK,  16'h0040, 16'h0001, 0, 0, 0, 16'h0000);
      step(16'h0040, 1, IDL, 3'b000, 0, OK,  16'h0,    16'h0040, 0, 0, 0, 16'h0000);
      step(16'h0040, 1, IDL, 3'b000, 0, OK,  16'h0,    16'h0040, 6, 0, 0, 16'h0000);
      // Simultaneous split set and resume on master 7: set wins.
      step(16'h0080, 1, IDL, 3'b000, 0, OK,  16'h0,    16'h0080, 6, 6, 0, 16'h0000);
      step(16'h0080, 1, IDL, 3'b000, 0, OK,  16'h0,    16'h0080, 7, 6, 0, 16'h0000);
      step(16'h0080, 1, IDL, 3'b000, 0, OK,  16'h0,    16'h0080, 7, 7, 0, 16'h0000);
      step(16'h0080, 0, IDL, 3'b000, 0, SPL, 16'h0080, 16'h0080, 7, 7, 0, 16'h0080);
      step(16'h0080, 1, IDL, 3'b000, 0, SPL, 16'h0,    16'h0001, 7, 7, 0, 16'h0080);
      step(16'h0000, 1, IDL, 3'b000, 0, OK,  16'h0080, 16'h0001, 0, 7, 0, 16'h0000);
      step(16'h0000, 1, IDL, 3'b000, 0, OK,  16'h0,    16'h0001, 0, 0, 0, 16'h0000);
      // Master 0 can never be split-masked.
      step(16'h0000, 0, IDL, 3'b000, 0, SPL, 16'h0001, 16'h0001, 0, 0, 0, 16'h0000);
      step(16'h0000, 1, IDL, 3'b000, 0, SPL, 16'h0,    16'h0001, 0, 0, 0, 16'h0000);
      // 8-beat burst by master 2 aborted by ERROR; master 3 takes over.
      step(16'h0004, 1, IDL, 3'b000, 0, OK,  16'h0, 16'h0004, 0, 0, 0, 16'h0);
      step(16'h0004, 1, IDL, 3'b000, 0, OK,  16'h0, 16'h0004, 2, 0, 0, 16'h0);
      step(16'h0004, 1, NSQ, 3'b100, 0, OK,  16'h0, 16'h0004, 2, 2, 0, 16'h0);
      step(16'h0008, 1, SQ,  3'b100, 0, OK,  16'h0, 16'h0004, 2, 2, 0, 16'h0);
      step(16'h0008, 1, SQ,  3'b100, 0, OK,  16'h0, 16'h0004, 2, 2, 0, 16'h0);
      step(16'h0008, 0, SQ,  3'b100, 0, ERR, 16'h0, 16'h0004, 2, 2, 0, 16'h0);
      step(16'h0008, 1, IDL, 3'b000, 0, ERR, 16'h0, 16'h0008, 2, 2, 0, 16'h0);
      step(16'h0008, 1, IDL, 3'b000, 0, OK,  16'h0, 16'h0008, 3, 2, 0, 16'h0);
      // 16-beat burst by master 5 cut short by an asynchronous reset.
      step(16'h0020, 1, NSQ, 3'b111, 0, OK,  16'h0, 16'h0020, 3, 3, 0, 16'h0);
      step(16'h0002, 1, SQ,  3'b111, 0, OK,  16'h0, 16'h0020, 5, 3, 0, 16'h0);
      step_id++;
      hrst_n = 1'b0;
      exp_q.push_back(mk(16'h0001, 0, 0, 0, 16'h0));
      @(negedge hclk);
      hrst_n = 1'b1;
      step(16'h0002, 1, SQ,  3'b111, 0, OK,  16'h0, 16'h0002, 0, 0, 0, 16'h0);
      step(16'h0002, 1, IDL, 3'b000, 0, OK,  16'h0, 16'h0002, 1, 0, 0, 16'h0);

      repeat (3) @(posedge hclk);
      #4;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ahb_master_sel.md
AHB_MASTER_SEL -- requirements
Module: ahb_master_sel

Interface
REQ-001 SHALL have port hclk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port hrst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port grant_req  input  16  grant vector from grant generator; may be zero or multi-hot.
REQ-004 SHALL have port hready  input  1  bus transfer-complete indicator.
REQ-005 SHALL have port htrans  input  2  transfer type of current owner (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-006 SHALL have port hburst  input  3  burst type of current owner (SINGLE=000, INCR=001, WRAP4/INCR4=01x, WRAP8/INCR8=10x, WRAP16/INCR16=11x).
REQ-007 SHALL have port hlock_m  input  1  lock request of current address-phase owner.
REQ-008 SHALL have port hresp  input  2  slave response (OKAY=00, ERROR=01, RETRY=10, SPLIT=11).
REQ-009 SHALL have port hsplit  input  16  split-resume pulses from slaves, one bit per master.
REQ-010 SHALL have port hgrant  output  16  one-hot registered bus grant.
REQ-011 SHALL have port hmaster  output  4  address-phase owner index.
REQ-012 SHALL have port hmaster_d  output  4  data-phase owner index.
REQ-013 SHALL have port hmastlock  output  1  current address phase is locked.
REQ-014 SHALL have port split_mask  output  16  masters currently split; returned to grant generator.

Function
REQ-015 Candidate = grant_req & ~split_mask; selected master = lowest set bit; candidate zero -> master 0 (default master).
REQ-016 Master 0 SHALL never be split-masked; split_mask[0] and hsplit[0] are hardwired to 0.
REQ-017 States: IDLE (no burst in progress), BURST (fixed-length burst in progress), LOCK (owner holds lock).
REQ-018 Arbitration point is any cycle with hready=1 in state IDLE, or in BURST with beat count 0 and hlock_m=0; hgrant <= one-hot(selected) on the next edge.
REQ-019 hgrant SHALL hold its value outside arbitration points.
REQ-020 hmaster <= encode(hgrant) on every edge with hready=1; hmaster_d <= hmaster on every edge with hready=1.
REQ-021 hmastlock <= hlock_m & (htrans!=IDLE) on every edge with hready=1.
REQ-022 Beat counter, 4 bits: NONSEQ & hready loads 3/7/15 for 4/8/16-beat bursts and 0 otherwise; SEQ & hready decrements; BUSY holds; counter saturates at 0.
REQ-023 Transitions: IDLE->BURST on NONSEQ & hready with a loaded count >0; BURST->IDLE when count reaches 0; any state->LOCK on hready & hlock_m; LOCK->IDLE on hready & ~hlock_m & htrans IDLE or NONSEQ.
REQ-024 In LOCK, hgrant SHALL be frozen regardless of grant_req.
REQ-025 hresp SPLIT with hready=0 (first response cycle) sets split_mask[hmaster_d], clears count, forces state IDLE; rearbitration follows at the next hready=1.
REQ-026 hresp RETRY or ERROR with hready=0 clears count and forces state IDLE; split_mask is unchanged.
REQ-027 hsplit[i]=1 clears split_mask[i] on the next edge; simultaneous set and clear of the same bit -> set wins.
REQ-028 SPLIT/RETRY responses SHALL override LOCK; the lock is dropped and the state is IDLE.
REQ-029 No combinational path from any input to any output; every output is registered.

Reset
REQ-030 On hrst_n=0, asynchronously: hgrant=16'h0001, hmaster=0, hmaster_d=0, hmastlock=0, split_mask=0, count=0, state IDLE.
REQ-031 Reset asserted mid-burst or mid-lock SHALL abort immediately; the first arbitration after release SHALL follow REQ-015.

Verification
REQ-032 Reset release, grant_req=0, hready=1 -> hgrant=0001 and hmaster=0 held indefinitely.
REQ-033 grant_req=16'h0024, hready=1, htrans IDLE -> hgrant=0004 next edge, hmaster=2 one edge later, hmaster_d=2 after a further edge.
REQ-034 Master 3 issues INCR4 (NONSEQ + 3 SEQ) while grant_req switches to master 5 after beat 1 -> hgrant stays 0008 until last SEQ accepted, then becomes 0020.
REQ-035 Master 4 issues a locked transfer with hlock_m=1 for 6 cycles while grant_req=bit 1 -> hmastlock=1 and hgrant=0010 frozen; release on IDLE -> hgrant=0002.
REQ-036 hmaster_d=6 receives SPLIT (hready=0 then 1) -> split_mask=0040, master 6 request ignored; hsplit[6] pulse -> mask 0000, master 6 grantable next arbitration point.
REQ-037 Same-cycle SPLIT for master 7 and hsplit[7] -> split_mask[7]=1; hsplit[0] pulse and SPLIT on master 0 -> split_mask[0] stays 0.
